// File: rtl/down_counter.sv
// Loadable down counter with one-shot / auto-reload modes.
// A load strobe captures the period and mode, then enabled cycles count the
// period down. When the count leaves 1 the block raises a one-cycle terminal
// count pulse. Auto-reload then restarts from the captured period; one-shot
// parks in DONE with the count at zero.
module down_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,       // active-low, asynchronous
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mode,      // 1 = auto-reload, 0 = one-shot
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] count_q,  count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             mode_q,   mode_d;
   logic             tc_q,     tc_d;

   // State register: every piece of state clears immediately on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         tc_q     <= tc_d;
      end
   end

   // Next-state logic: load wins over enable in every state; tc only on expiry.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      tc_d     = 1'b0;

      if (load) begin
         reload_d = load_val;
         mode_d   = mode;
         count_d  = load_val;
         // A zero period has nothing to count, so it lands back in IDLE.
         state_d  = (load_val != '0) ? RUN : IDLE;
      end else begin
         unique case (state_q)
            RUN: begin
               if (en) begin
                  if (count_q > ONE) begin
                     count_d = count_q - ONE;
                  end else if (count_q == ONE) begin
                     tc_d = 1'b1;
                     if (mode_q) begin
                        count_d = reload_q;
                     end else begin
                        count_d = '0;
                        state_d = DONE;
                     end
                  end
                  // A zero count in RUN is unreachable; holding it avoids any
                  // chance of wrapping to all-ones.
               end
            end
            IDLE, DONE: begin
               count_d = '0;
            end
            default: begin
               state_d = IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   // Output decode: status flags come straight from the registered state.
   always_comb begin
      q    = count_q;
      tc   = tc_q;
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: a table of vectors fed through an
// expected-result queue, plus hand-written reset and full-range sequences.
module tb_down_counter;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         mode = 1'b0;
   logic [W-1:0] q;
   logic         tc;
   logic         busy;
   logic         done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic         en;
      logic         load;
      logic [W-1:0] lv;
      logic         mode;
      logic [W-1:0] q;
      logic         tc;
      logic         busy;
      logic         done;
      string        name;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic         tc;
      logic         busy;
      logic         done;
      string        name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   down_counter #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .mode     (mode),
      .q        (q),
      .tc       (tc),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check_now(input string nm, input logic [W-1:0] eq, input logic etc,
                            input logic eb, input logic ed);
      checks++;
      if (q !== eq || tc !== etc || busy !== eb || done !== ed) begin
         failures++;
         $display("FAIL %s: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                  nm, q, tc, busy, done, eq, etc, eb, ed);
      end else begin
         $display("ok   %s: q=%0d tc=%b busy=%b done=%b", nm, q, tc, busy, done);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply(input logic e, input logic ld, input logic [W-1:0] lv, input logic m,
                        input logic [W-1:0] eq, input logic etc, input logic eb,
                        input logic ed, input string nm);
      exp_t x;
      en = e; load = ld; load_val = lv; mode = m;
      x.q = eq; x.tc = etc; x.busy = eb; x.done = ed; x.name = nm;
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty, got q=%0d want an entry", nm, q);
      end else begin
         x = sb.pop_front();
         check_now(x.name, x.q, x.tc, x.busy, x.done);
      end
   endtask

   function automatic void add(input logic e, input logic ld, input logic [W-1:0] lv,
                               input logic m, input logic [W-1:0] eq, input logic etc,
                               input logic eb, input logic ed, input string nm);
      vec_t v;
      v.en = e; v.load = ld; v.lv = lv; v.mode = m;
      v.q = eq; v.tc = etc; v.busy = eb; v.done = ed; v.name = nm;
      vecs.push_back(v);
   endfunction

   initial begin
      // Idle with enable only: nothing may happen.
      for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 0, "idle_en");
      // One-shot from 4.
      add(1, 1, 4, 0, 4, 0, 1, 0, "os_load4");
      add(1, 0, 0, 0, 3, 0, 1, 0, "os_q3");
      add(1, 0, 0, 0, 2, 0, 1, 0, "os_q2");
      add(1, 0, 0, 0, 1, 0, 1, 0, "os_q1");
      add(1, 0, 0, 0, 0, 1, 0, 1, "os_expire");
      add(1, 0, 0, 0, 0, 0, 0, 1, "os_done_hold1");
      add(1, 0, 0, 0, 0, 0, 0, 1, "os_done_hold2");
      // Auto-reload period 3, nine enabled cycles.
      add(1, 1, 3, 1, 3, 0, 1, 0, "ar_load3");
      for (int i = 0; i < 3; i++) begin
         add(1, 0, 0, 1, 2, 0, 1, 0, "ar_q2");
         add(1, 0, 0, 1, 1, 0, 1, 0, "ar_q1");
         add(1, 0, 0, 1, 3, 1, 1, 0, "ar_reload_tc");
      end
      // Auto-reload with enable toggling.
      add(1, 1, 3, 1, 3, 0, 1, 0, "tog_load3");
      add(1, 0, 0, 1, 2, 0, 1, 0, "tog_en1_q2");
      add(0, 0, 0, 1, 2, 0, 1, 0, "tog_en0_hold2");
      add(1, 0, 0, 1, 1, 0, 1, 0, "tog_en1_q1");
      add(0, 0, 0, 1, 1, 0, 1, 0, "tog_en0_hold1");
      add(1, 0, 0, 1, 3, 1, 1, 0, "tog_en1_tc");
      add(0, 0, 0, 1, 3, 0, 1, 0, "tog_en0_notc");
      add(1, 0, 0, 1, 2, 0, 1, 0, "tog_en1_q2b");
      // Load beats expiry when q==1 and en=1.
      add(1, 0, 0, 1, 1, 0, 1, 0, "pre_q1");
      add(1, 1, 6, 1, 6, 0, 1, 0, "load_over_tc");
      add(1, 0, 0, 1, 5, 0, 1, 0, "after_reload_q5");
      // Zero load goes idle.
      add(1, 1, 0, 1, 0, 0, 0, 0, "load0_idle");
      add(1, 0, 0, 1, 0, 0, 0, 0, "load0_en_ignored");
      // Period 1 in auto-reload: tc on every enabled cycle.
      add(1, 1, 1, 1, 1, 0, 1, 0, "p1_load");
      add(1, 0, 0, 1, 1, 1, 1, 0, "p1_tc_a");
      add(1, 0, 0, 1, 1, 1, 1, 0, "p1_tc_b");
      add(0, 0, 0, 1, 1, 0, 1, 0, "p1_en0");
      add(1, 0, 0, 1, 1, 1, 1, 0, "p1_tc_c");
      // One-shot from 1.
      add(1, 1, 1, 0, 1, 0, 1, 0, "os1_load");
      add(1, 0, 0, 0, 0, 1, 0, 1, "os1_expire");
      // Mode is captured at load, later mode input ignored.
      add(1, 1, 2, 1, 2, 0, 1, 0, "cap_load_ar");
      add(1, 0, 0, 0, 1, 0, 1, 0, "cap_q1");
      add(1, 0, 0, 0, 2, 1, 1, 0, "cap_still_reload");
      // Load from DONE restarts.
      add(1, 1, 1, 0, 1, 0, 1, 0, "d_load1");
      add(1, 0, 0, 0, 0, 1, 0, 1, "d_expire");
      add(0, 1, 2, 0, 2, 0, 1, 0, "d_reload_from_done");

      // Reset state.
      #2;
      check_now("reset_state", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i])
         apply(vecs[i].en, vecs[i].load, vecs[i].lv, vecs[i].mode,
               vecs[i].q, vecs[i].tc, vecs[i].busy, vecs[i].done, vecs[i].name);

      // Asynchronous reset mid-count: clears without a clock edge.
      apply(1, 1, 5, 1, 5, 0, 1, 0, "rs_load5");
      apply(1, 0, 0, 1, 4, 0, 1, 0, "rs_q4");
      apply(1, 0, 0, 1, 3, 0, 1, 0, "rs_q3");
      apply(1, 0, 0, 1, 2, 0, 1, 0, "rs_q2");
      #1 rst = 1'b0;
      #1 check_now("async_rst_clear", 0, 0, 0, 0);
      #1 rst = 1'b1;
      for (int i = 0; i < 3; i++) apply(1, 0, 0, 1, 0, 0, 0, 0, "post_rst_idle");

      // Full-range one-shot from all-ones.
      apply(1, 1, 8'hFF, 0, 8'hFF, 0, 1, 0, "full_load");
      for (int i = 1; i <= 255; i++) begin
         logic [W-1:0] eq;
         eq = W'(255 - i);
         apply(1, 0, 0, 0, eq, (i == 255), (i != 255), (i == 255),
               (i == 255) ? "full_expire" : "full_count");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
